// File: rtl/a_bus_arbiter_ctrl_if.sv
// Handshake/select bundle between the bus masters and the arbiter controller.
// The master modport is the controller's view; slave is the requesting masters' view.
interface a_bus_arbiter_ctrl_if #(
    parameter int unsigned NO_MASTERS = 2,
    parameter int unsigned NO_SLAVES  = 3,
    parameter int unsigned S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int unsigned M_ID_WIDTH = $clog2(NO_MASTERS)
);
    logic [NO_MASTERS*S_ID_WIDTH-1:0] req_slave;
    logic [NO_MASTERS-1:0]            m_done;
    logic [NO_MASTERS-1:0]            m_ack;
    logic [NO_MASTERS-1:0]            grant;
    logic [NO_MASTERS-1:0]            hold;
    logic [M_ID_WIDTH-1:0]            cur_master;
    logic [S_ID_WIDTH-1:0]            cur_slave;
    logic                             bus_busy;

    modport master (
        input  req_slave, m_done, m_ack,
        output grant, hold, cur_master, cur_slave, bus_busy
    );

    modport slave (
        output req_slave, m_done, m_ack,
        input  grant, hold, cur_master, cur_slave, bus_busy
    );
endinterface

// File: rtl/a_bus_arbiter_ctrl.sv
// Shared-bus sequencing controller: fixed-priority grant, preemption via hold/ack handshake.
// Define A_SPLIT_EN to add the ACTIVE-cycle timer and split-transaction rule.
module a_bus_arbiter_ctrl #(
    parameter int unsigned NO_MASTERS    = 2,
    parameter int unsigned NO_SLAVES     = 3,
    parameter int unsigned S_ID_WIDTH    = $clog2(NO_SLAVES + 1),
    parameter int unsigned M_ID_WIDTH    = $clog2(NO_MASTERS),
    parameter int unsigned THRESH_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    a_bus_arbiter_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_PREEMPT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [NO_MASTERS-1:0]   grant_q, grant_d;
    logic [NO_MASTERS-1:0]   hold_q, hold_d;
    logic [M_ID_WIDTH-1:0]   cur_master_q, cur_master_d;
    logic [S_ID_WIDTH-1:0]   cur_slave_q, cur_slave_d;
    logic                    busy_q, busy_d;
    logic                    split_q, split_d;
    logic                    thresh_c;

    logic [S_ID_WIDTH-1:0]   req_id [NO_MASTERS];
    logic [NO_MASTERS-1:0]   req_nz;

    logic                    idle_found, prio_found, sw_found, alt_found;
    logic [M_ID_WIDTH-1:0]   idle_idx, sw_idx, alt_idx;
    logic                    cand_found;
    logic                    cur_done_c, cur_ack_c;

    // Unpack per-master slave requests
    always_comb begin
        for (int i = 0; i < NO_MASTERS; i++) begin
            req_id[i] = bus.req_slave[i*S_ID_WIDTH +: S_ID_WIDTH];
            req_nz[i] = |req_id[i];
        end
    end

    // Lowest-index selections: any requester, higher priority than current,
    // other requester on a different slave, any other requester
    always_comb begin
        idle_found = 1'b0;
        prio_found = 1'b0;
        sw_found   = 1'b0;
        alt_found  = 1'b0;
        idle_idx   = '0;
        sw_idx     = '0;
        alt_idx    = '0;
        for (int i = 0; i < NO_MASTERS; i++) begin
            if (req_nz[i] && !idle_found) begin
                idle_found = 1'b1;
                idle_idx   = M_ID_WIDTH'(i);
            end
            if (req_nz[i] && (M_ID_WIDTH'(i) < cur_master_q)) begin
                prio_found = 1'b1;
            end
            if (req_nz[i] && (M_ID_WIDTH'(i) != cur_master_q) &&
                (req_id[i] != cur_slave_q) && !sw_found) begin
                sw_found = 1'b1;
                sw_idx   = M_ID_WIDTH'(i);
            end
            if (req_nz[i] && (M_ID_WIDTH'(i) != cur_master_q) && !alt_found) begin
                alt_found = 1'b1;
                alt_idx   = M_ID_WIDTH'(i);
            end
        end
    end

    assign cand_found = thresh_c ? sw_found : prio_found;
    assign cur_done_c = bus.m_done[cur_master_q] | ~req_nz[cur_master_q];
    assign cur_ack_c  = bus.m_ack[cur_master_q] | bus.m_done[cur_master_q];

`ifdef A_SPLIT_EN
    localparam int unsigned T_WIDTH = $clog2(THRESH_CYCLES + 1);

    logic [T_WIDTH-1:0] timer_q, timer_d;

    assign thresh_c = (timer_q == T_WIDTH'(THRESH_CYCLES));

    // Restart on every new grant, count saturating while the grant is ACTIVE
    always_comb begin
        timer_d = timer_q;
        if ((state_d == ST_ACTIVE) && (state_q != ST_ACTIVE)) begin
            timer_d = '0;
        end else if ((state_q == ST_ACTIVE) && !thresh_c) begin
            timer_d = timer_q + T_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign thresh_c = 1'b0;
`endif

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        hold_d       = hold_q;
        cur_master_d = cur_master_q;
        cur_slave_d  = cur_slave_q;
        busy_d       = busy_q;
        split_d      = split_q;

        case (state_q)
            ST_IDLE: begin
                if (idle_found) begin
                    state_d      = ST_ACTIVE;
                    grant_d      = NO_MASTERS'(1) << idle_idx;
                    cur_master_d = idle_idx;
                    cur_slave_d  = req_id[idle_idx];
                    busy_d       = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (cur_done_c) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    hold_d      = '0;
                    cur_slave_d = '0;
                    busy_d      = 1'b0;
                end else if (cand_found) begin
                    state_d = ST_PREEMPT;
                    hold_d  = NO_MASTERS'(1) << cur_master_q;
                    split_d = thresh_c;
                end
            end

            ST_PREEMPT: begin
                if (cur_ack_c) begin
                    hold_d  = '0;
                    split_d = 1'b0;
                    // A split hands over to a requester of another slave when one exists
                    if (split_q && sw_found) begin
                        state_d      = ST_ACTIVE;
                        grant_d      = NO_MASTERS'(1) << sw_idx;
                        cur_master_d = sw_idx;
                        cur_slave_d  = req_id[sw_idx];
                    end else if (alt_found) begin
                        state_d      = ST_ACTIVE;
                        grant_d      = NO_MASTERS'(1) << alt_idx;
                        cur_master_d = alt_idx;
                        cur_slave_d  = req_id[alt_idx];
                    end else begin
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                        cur_slave_d = '0;
                        busy_d      = 1'b0;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                hold_d      = '0;
                cur_slave_d = '0;
                busy_d      = 1'b0;
                split_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            hold_q       <= '0;
            cur_master_q <= '0;
            cur_slave_q  <= '0;
            busy_q       <= 1'b0;
            split_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            hold_q       <= hold_d;
            cur_master_q <= cur_master_d;
            cur_slave_q  <= cur_slave_d;
            busy_q       <= busy_d;
            split_q      <= split_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.hold       = hold_q;
    assign bus.cur_master = cur_master_q;
    assign bus.cur_slave  = cur_slave_q;
    assign bus.bus_busy   = busy_q;

endmodule

// File: tb/tb_a_bus_arbiter_ctrl.sv
// Directed bench for a_bus_arbiter_ctrl: a 2-master and a 3-master instance share clk/rst.
// The 3-master scenario checks the split rule when A_SPLIT_EN is defined, its absence otherwise.
module tb_a_bus_arbiter_ctrl;

    logic clk;
    logic rst;

    int total;
    int bad;

    a_bus_arbiter_ctrl_if #(.NO_MASTERS(2), .NO_SLAVES(3)) bus2 ();
    a_bus_arbiter_ctrl_if #(.NO_MASTERS(3), .NO_SLAVES(3)) bus3 ();

    a_bus_arbiter_ctrl #(.NO_MASTERS(2), .NO_SLAVES(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    a_bus_arbiter_ctrl #(.NO_MASTERS(3), .NO_SLAVES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hold_seen;
        int grant_lost;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus2.req_slave = '0;
        bus2.m_done    = '0;
        bus2.m_ack     = '0;
        bus3.req_slave = '0;
        bus3.m_done    = '0;
        bus3.m_ack     = '0;
        tick();
        tick();

        check("rst_grant",  32'(bus2.grant), 32'h0);
        check("rst_hold",   32'(bus2.hold), 32'h0);
        check("rst_master", 32'(bus2.cur_master), 32'h0);
        check("rst_slave",  32'(bus2.cur_slave), 32'h0);
        check("rst_busy",   32'(bus2.bus_busy), 32'h0);
        rst = 1'b0;
        tick();

        // Simultaneous requests: M0 wins, then M1 via IDLE
        bus2.req_slave = {2'd2, 2'd1};
        tick();
        check("t2_grant",  32'(bus2.grant), 32'h1);
        check("t2_master", 32'(bus2.cur_master), 32'h0);
        check("t2_slave",  32'(bus2.cur_slave), 32'h1);
        check("t2_busy",   32'(bus2.bus_busy), 32'h1);
        bus2.m_done    = 2'b01;
        bus2.req_slave = {2'd2, 2'd0};
        tick();
        bus2.m_done = 2'b00;
        check("t2_idle_grant", 32'(bus2.grant), 32'h0);
        check("t2_idle_busy",  32'(bus2.bus_busy), 32'h0);
        tick();
        check("t2_m1_grant",  32'(bus2.grant), 32'h2);
        check("t2_m1_master", 32'(bus2.cur_master), 32'h1);
        check("t2_m1_slave",  32'(bus2.cur_slave), 32'h2);

        // Completion and higher-priority request in the same cycle
        bus2.m_done    = 2'b10;
        bus2.req_slave = {2'd0, 2'd1};
        tick();
        bus2.m_done = 2'b00;
        check("t6_idle_grant", 32'(bus2.grant), 32'h0);
        check("t6_no_hold",    32'(bus2.hold), 32'h0);
        tick();
        check("t6_grant", 32'(bus2.grant), 32'h1);
        check("t6_slave", 32'(bus2.cur_slave), 32'h1);
        bus2.m_done    = 2'b01;
        bus2.req_slave = '0;
        tick();
        bus2.m_done = 2'b00;
        check("t6_release", 32'(bus2.grant), 32'h0);

        // Priority preemption of M1 by M0
        bus2.req_slave = {2'd3, 2'd0};
        tick();
        check("t3_grant", 32'(bus2.grant), 32'h2);
        check("t3_slave", 32'(bus2.cur_slave), 32'h3);
        tick();
        tick();
        bus2.req_slave = {2'd3, 2'd1};
        tick();
        check("t3_hold",       32'(bus2.hold), 32'h2);
        check("t3_hold_grant", 32'(bus2.grant), 32'h2);
        check("t3_hold_busy",  32'(bus2.bus_busy), 32'h1);
        tick();
        tick();
        check("t3_hold_kept",  32'(bus2.hold), 32'h2);
        check("t3_grant_kept", 32'(bus2.grant), 32'h2);
        bus2.m_ack = 2'b10;
        tick();
        bus2.m_ack = 2'b00;
        check("t3_sw_grant",  32'(bus2.grant), 32'h1);
        check("t3_sw_master", 32'(bus2.cur_master), 32'h0);
        check("t3_sw_slave",  32'(bus2.cur_slave), 32'h1);
        check("t3_sw_hold",   32'(bus2.hold), 32'h0);
        check("t3_sw_busy",   32'(bus2.bus_busy), 32'h1);
        bus2.m_done    = 2'b01;
        bus2.req_slave = {2'd3, 2'd0};
        tick();
        bus2.m_done = 2'b00;
        check("t3_idle", 32'(bus2.grant), 32'h0);
        tick();
        check("t3_regrant",       32'(bus2.grant), 32'h2);
        check("t3_regrant_slave", 32'(bus2.cur_slave), 32'h3);

        // Asynchronous reset while M1 is active
        #3;
        rst = 1'b1;
        #1;
        check("t1_grant", 32'(bus2.grant), 32'h0);
        check("t1_hold",  32'(bus2.hold), 32'h0);
        check("t1_slave", 32'(bus2.cur_slave), 32'h0);
        check("t1_busy",  32'(bus2.bus_busy), 32'h0);
        bus2.req_slave = '0;
        tick();
        rst = 1'b0;
        tick();

        // Long-running M0 with M1 (same slave) and M2 (other slave) waiting
        bus3.req_slave = {2'd0, 2'd0, 2'd1};
        tick();
        check("t45_grant", 32'(bus3.grant), 32'h1);
        bus3.req_slave = {2'd2, 2'd1, 2'd1};
        hold_seen  = 0;
        grant_lost = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (bus3.hold != 3'b000) hold_seen = 1;
            if (bus3.grant != 3'b001) grant_lost = 1;
        end
        check("t45_no_early_hold", 32'(hold_seen), 32'h0);
        check("t45_grant_kept",    32'(grant_lost), 32'h0);
`ifdef A_SPLIT_EN
        tick();
        check("t4_hold",       32'(bus3.hold), 32'h1);
        check("t4_hold_grant", 32'(bus3.grant), 32'h1);
        bus3.m_ack = 3'b001;
        tick();
        bus3.m_ack = 3'b000;
        check("t4_grant",  32'(bus3.grant), 32'h4);
        check("t4_master", 32'(bus3.cur_master), 32'h2);
        check("t4_slave",  32'(bus3.cur_slave), 32'h2);
        check("t4_hold_released", 32'(bus3.hold), 32'h0);
`else
        for (int k = 0; k < 24; k++) begin
            tick();
            if (bus3.hold != 3'b000) hold_seen = 1;
            if (bus3.grant != 3'b001) grant_lost = 1;
        end
        check("t5_no_hold",    32'(hold_seen), 32'h0);
        check("t5_grant_kept", 32'(grant_lost), 32'h0);
        bus3.m_done    = 3'b001;
        bus3.req_slave = {2'd2, 2'd1, 2'd0};
        tick();
        bus3.m_done = 3'b000;
        check("t5_idle", 32'(bus3.grant), 32'h0);
        tick();
        check("t5_next_grant", 32'(bus3.grant), 32'h2);
        check("t5_next_slave", 32'(bus3.cur_slave), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
